// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and the shared memory bus.
// slave = arbiter side, master = requesters + memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_valid, if_rdata,
    output d_gnt, d_valid, d_rdata,
    output mem_addr, mem_wdata,
    output mem_re, mem_we, busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_addr, mem_wdata,
    input  mem_re, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one sync memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate on collisions.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_own_d;
  logic              r_we;
  logic              r_mem_re;
  logic              r_mem_we;
  logic              r_if_gnt;
  logic              r_d_gnt;
  logic              r_if_valid;
  logic              r_d_valid;
  logic              r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_any;
  logic w_pick_d;
  logic w_store;

  assign w_any   = bus.if_req | bus.d_req;
  assign w_store = w_pick_d & bus.d_we;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On a collision the previous winner yields.
  assign w_pick_d = bus.d_req &
                    (~bus.if_req | ~r_last_d);

  // Remember who won the last arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_IDLE && w_any) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = bus.d_req;
`endif

  // Three-phase transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_own_d     <= 1'b0;
      r_we        <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_ACCESS;
            r_busy     <= 1'b1;
            r_own_d    <= w_pick_d;
            r_we       <= w_store;
            r_mem_addr <= w_pick_d ? bus.d_addr
                                   : bus.if_addr;
            r_mem_wdata <= w_pick_d ? bus.d_wdata
                                    : '0;
            r_mem_re   <= ~w_store;
            r_mem_we   <= w_store;
            r_d_gnt    <= w_pick_d;
            r_if_gnt   <= ~w_pick_d;
          end
        end
        S_ACCESS: begin
          r_state    <= S_RESP;
          r_mem_re   <= 1'b0;
          r_mem_we   <= 1'b0;
          r_if_gnt   <= 1'b0;
          r_d_gnt    <= 1'b0;
          r_d_valid  <= r_own_d;
          r_if_valid <= ~r_own_d;
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_if_valid <= 1'b0;
          r_d_valid  <= 1'b0;
          if (r_own_d) begin
            r_d_rdata <= r_we ? '0 : bus.mem_rdata;
          end else begin
            r_if_rdata <= bus.mem_rdata;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_mem_re   <= 1'b0;
          r_mem_we   <= 1'b0;
          r_if_gnt   <= 1'b0;
          r_d_gnt    <= 1'b0;
          r_if_valid <= 1'b0;
          r_d_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.d_gnt     = r_d_gnt;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_valid   = r_d_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.busy      = r_busy;

  // Memory data arrives during RESP; show it in the
  // valid cycle, then hold the captured copy.
  assign bus.if_rdata = r_if_valid ? bus.mem_rdata
                                   : r_if_rdata;
  assign bus.d_rdata  = r_d_valid
                      ? (r_we ? '0 : bus.mem_rdata)
                      : r_d_rdata;

endmodule
